serial_pattern_source: RTL

Serial bit-stream transmitter that produces the one-bit-per-clock input stream consumed by the sequence-detector state machines. A parallel pattern (up to WIDTH bits) is loaded, then shifted out MSB-first on X, one bit per enabled clock. It supports:

- programmable length,
- back-to-back repetition,
- a pause input,
- a start/busy/done handshake.

It replaces hand-written bit-stream stimulus and drives the detector's X input directly in system-level benches and on the board.

---
 rtl/serial_pattern_source.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_pattern_source.sv
// Serial pattern source: shifts a loaded pattern out MSB-first on o_x,
// with programmable length, frame repetition, hold and start/done handshake.
module serial_pattern_source #(
  parameter int WIDTH = 64,
  parameter int LEN_W = 7,
  parameter int REP_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic [LEN_W-1:0] i_len,
  input  logic [REP_W-1:0] i_repeat,
  input  logic             i_start,
  input  logic             i_hold,
  output logic             o_x,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_bit_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_data_s;
  logic [LEN_W-1:0] r_len_s;
  logic [REP_W-1:0] r_rep_s;
  logic             r_armed;
  logic [WIDTH-1:0] r_frame;
  logic [LEN_W-1:0] r_len_f;
  logic [WIDTH-1:0] r_sh;
  logic [LEN_W-1:0] r_bcnt;
  logic [REP_W-1:0] r_rcnt;

  logic [LEN_W-1:0] w_len_in;
  logic [WIDTH-1:0] w_go_data;
  logic [LEN_W-1:0] w_go_len;
  logic [REP_W-1:0] w_go_rep;
  logic [WIDTH-1:0] w_go_sh;
  logic             w_start_ok;

  assign w_len_in   = (i_len == '0 || i_len > L_MAX) ? L_MAX : i_len;
  assign w_go_data  = i_load ? i_data : r_data_s;
  assign w_go_len   = i_load ? w_len_in : r_len_s;
  assign w_go_rep   = i_load ? i_repeat : r_rep_s;
  // left-align so the first bit to send sits at the MSB
  assign w_go_sh    = w_go_data << (L_MAX - w_go_len);
  assign w_start_ok = i_start && (r_armed || i_load);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_data_s  <= '0;
      r_len_s   <= '0;
      r_rep_s   <= '0;
      r_armed   <= 1'b0;
      r_frame   <= '0;
      r_len_f   <= '0;
      r_sh      <= '0;
      r_bcnt    <= '0;
      r_rcnt    <= '0;
      o_x       <= 1'b0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_bit_cnt <= '0;
    end else begin
      if (i_load) begin
        r_data_s <= i_data;
        r_len_s  <= w_len_in;
        r_rep_s  <= i_repeat;
        r_armed  <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          o_x       <= 1'b0;
          o_valid   <= 1'b0;
          o_done    <= 1'b0;
          o_bit_cnt <= '0;
          if (w_start_ok) begin
            r_state <= S_SHIFT;
            o_busy  <= 1'b1;
            r_frame <= w_go_sh;
            r_len_f <= w_go_len;
            r_sh    <= w_go_sh;
            r_bcnt  <= w_go_len - 1'b1;
            r_rcnt  <= w_go_rep;
          end
        end
        S_SHIFT: begin
          if (i_hold) begin
            o_valid <= 1'b0;
          end else begin
            o_x       <= r_sh[WIDTH-1];
            o_valid   <= 1'b1;
            o_bit_cnt <= r_bcnt;
            if (r_bcnt == '0) begin
              if (r_rcnt != '0) begin
                r_sh   <= r_frame;
                r_bcnt <= r_len_f - 1'b1;
                r_rcnt <= r_rcnt - 1'b1;
              end else begin
                r_state <= S_FINISH;
              end
            end else begin
              r_sh   <= r_sh << 1;
              r_bcnt <= r_bcnt - 1'b1;
            end
          end
        end
        S_FINISH: begin
          o_x       <= 1'b0;
          o_valid   <= 1'b0;
          o_busy    <= 1'b0;
          o_done    <= 1'b1;
          o_bit_cnt <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
